// File: rtl/milano_pkg.sv
// Shared decoder types: multiply/divide operation encoding.
package milano_pkg;

    typedef enum logic [3:0] {
        MD_NONE      = 4'd0,
        MD_OP_MUL    = 4'd1,
        MD_OP_MULH   = 4'd2,
        MD_OP_MULHSU = 4'd3,
        MD_OP_MULHU  = 4'd4,
        MD_OP_DIV    = 4'd5,
        MD_OP_DIVU   = 4'd6,
        MD_OP_REM    = 4'd7,
        MD_OP_REMU   = 4'd8
    } md_opt_e;

endpackage

// File: rtl/md_sequencer_if.sv
// Request/result bundle between the ID-EX stage and the multiply/divide sequencer.
interface md_sequencer_if;

    logic                 md_valid_i;
    milano_pkg::md_opt_e  md_operate_i;
    logic [31:0]          md_operand_a_i;
    logic [31:0]          md_operand_b_i;
    logic                 md_kill_i;
    logic                 md_ready_o;
    logic                 md_stall_o;
    logic [31:0]          md_result_o;
    logic                 md_result_valid_o;

    // Pipeline side: issues requests, consumes stall and result.
    modport master (
        output md_valid_i, md_operate_i, md_operand_a_i, md_operand_b_i, md_kill_i,
        input  md_ready_o, md_stall_o, md_result_o, md_result_valid_o
    );

    // Sequencer side.
    modport slave (
        input  md_valid_i, md_operate_i, md_operand_a_i, md_operand_b_i, md_kill_i,
        output md_ready_o, md_stall_o, md_result_o, md_result_valid_o
    );

endinterface

// File: rtl/md_sequencer.sv
// Multi-cycle M-extension sequencer: 32-step shift-add multiply or restoring
// divide on operand magnitudes, followed by a sign fixup cycle.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | ready; accepts a request unless killed
// MUL    | one shift-add step per cycle, 32 steps
// DIV    | one restoring quotient bit per cycle, 32 steps
// FIXUP  | sign correction and word select, result registered
// DONE   | result valid pulse (suppressed by kill), pipeline released
module md_sequencer
    import milano_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_ni,
    md_sequencer_if.slave        md_if
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MUL   = 3'd1,
        S_DIV   = 3'd2,
        S_FIXUP = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e       state_q, state_d;
    md_opt_e      op_q, op_d;
    logic [5:0]   cnt_q, cnt_d;
    logic         neg_a_q, neg_a_d;
    logic         neg_b_q, neg_b_d;
    // MUL: {partial high, multiplier/low product}; DIV: low word is dividend/quotient
    logic [63:0]  acc_q, acc_d;
    // Multiplicand in MUL, divisor in DIV
    logic [31:0]  opnd_q, opnd_d;
    logic [31:0]  rem_q, rem_d;
    logic [31:0]  result_q, result_d;

    logic         accept;
    logic         a_signed, b_signed;
    logic         neg_a_in, neg_b_in;
    logic [31:0]  abs_a, abs_b;
    logic         is_mul_in;
    logic         b_zero, div_ovf;
    logic [31:0]  fast_res;

    logic [32:0]  mul_sum;
    logic [63:0]  mul_next;
    logic [32:0]  div_trial;
    logic         div_ok;
    logic [31:0]  rem_next;
    logic [31:0]  quo_next;

    logic [63:0]  prod_fix;
    logic [31:0]  quo_fix;
    logic [31:0]  rem_fix;
    logic [31:0]  fix_res;

    // Request decode: signedness, magnitudes and the fast-path special cases.
    always_comb begin
        accept    = (state_q == S_IDLE) && md_if.md_valid_i &&
                    (md_if.md_operate_i != MD_NONE) && !md_if.md_kill_i;
        a_signed  = (md_if.md_operate_i == MD_OP_MULH) || (md_if.md_operate_i == MD_OP_MULHSU) ||
                    (md_if.md_operate_i == MD_OP_DIV)  || (md_if.md_operate_i == MD_OP_REM);
        b_signed  = (md_if.md_operate_i == MD_OP_MULH) ||
                    (md_if.md_operate_i == MD_OP_DIV)  || (md_if.md_operate_i == MD_OP_REM);
        neg_a_in  = a_signed && md_if.md_operand_a_i[31];
        neg_b_in  = b_signed && md_if.md_operand_b_i[31];
        abs_a     = neg_a_in ? (~md_if.md_operand_a_i + 32'd1) : md_if.md_operand_a_i;
        abs_b     = neg_b_in ? (~md_if.md_operand_b_i + 32'd1) : md_if.md_operand_b_i;
        is_mul_in = (md_if.md_operate_i == MD_OP_MUL)    || (md_if.md_operate_i == MD_OP_MULH) ||
                    (md_if.md_operate_i == MD_OP_MULHSU) || (md_if.md_operate_i == MD_OP_MULHU);
        b_zero    = (md_if.md_operand_b_i == 32'd0);
        div_ovf   = ((md_if.md_operate_i == MD_OP_DIV) || (md_if.md_operate_i == MD_OP_REM)) &&
                    (md_if.md_operand_a_i == 32'h8000_0000) &&
                    (md_if.md_operand_b_i == 32'hFFFF_FFFF);
        fast_res  = 32'd0;
        if (b_zero) begin
            if ((md_if.md_operate_i == MD_OP_DIV) || (md_if.md_operate_i == MD_OP_DIVU))
                fast_res = 32'hFFFF_FFFF;
            else
                fast_res = md_if.md_operand_a_i;
        end else if (md_if.md_operate_i == MD_OP_DIV) begin
            fast_res = 32'h8000_0000;
        end
    end

    // One iteration of each datapath, plus the fixup/word select.
    always_comb begin
        mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
        mul_next  = {mul_sum, acc_q[31:1]};
        // Shifted partial remainder is 33 bits; borrow out means restore.
        div_trial = {rem_q, acc_q[31]} - {1'b0, opnd_q};
        div_ok    = !div_trial[32];
        rem_next  = div_ok ? div_trial[31:0] : {rem_q[30:0], acc_q[31]};
        quo_next  = {acc_q[30:0], div_ok};

        prod_fix  = (neg_a_q ^ neg_b_q) ? (~acc_q + 64'd1) : acc_q;
        quo_fix   = ((op_q == MD_OP_DIV) && (neg_a_q ^ neg_b_q)) ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
        rem_fix   = ((op_q == MD_OP_REM) && neg_a_q) ? (~rem_q + 32'd1) : rem_q;
        case (op_q)
            MD_OP_MUL:                           fix_res = prod_fix[31:0];
            MD_OP_MULH, MD_OP_MULHSU, MD_OP_MULHU: fix_res = prod_fix[63:32];
            MD_OP_DIV, MD_OP_DIVU:               fix_res = quo_fix;
            default:                             fix_res = rem_fix;
        endcase
    end

    // Next-state, datapath load/step and handshake outputs.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        rem_d    = rem_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d    = md_if.md_operate_i;
                    neg_a_d = neg_a_in;
                    neg_b_d = neg_b_in;
                    cnt_d   = 6'd0;
                    rem_d   = 32'd0;
                    if (is_mul_in) begin
                        acc_d   = {32'd0, abs_b};
                        opnd_d  = abs_a;
                        state_d = S_MUL;
                    end else if (b_zero || div_ovf) begin
                        result_d = fast_res;
                        state_d  = S_DONE;
                    end else begin
                        acc_d   = {32'd0, abs_a};
                        opnd_d  = abs_b;
                        state_d = S_DIV;
                    end
                end
            end
            S_MUL: begin
                acc_d = mul_next;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31)
                    state_d = S_FIXUP;
            end
            S_DIV: begin
                acc_d = {acc_q[63:32], quo_next};
                rem_d = rem_next;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31)
                    state_d = S_FIXUP;
            end
            S_FIXUP: begin
                result_d = fix_res;
                state_d  = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A flush overrides everything and leaves the last result untouched.
        if (md_if.md_kill_i) begin
            state_d  = S_IDLE;
            cnt_d    = 6'd0;
            result_d = result_q;
        end

        md_if.md_ready_o        = (state_q == S_IDLE);
        md_if.md_stall_o        = accept || (state_q == S_MUL) || (state_q == S_DIV) ||
                                  (state_q == S_FIXUP);
        md_if.md_result_valid_o = (state_q == S_DONE) && !md_if.md_kill_i;
        md_if.md_result_o       = result_q;
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            op_q     <= MD_NONE;
            cnt_q    <= 6'd0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            acc_q    <= 64'd0;
            opnd_q   <= 32'd0;
            rem_q    <= 32'd0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            rem_q    <= rem_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_md_sequencer.sv
// Directed bench for md_sequencer: results, latency, stall length, kill/reset recovery.
module tb_md_sequencer;
    import milano_pkg::*;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    md_sequencer_if md_if ();

    md_sequencer dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .md_if  (md_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present a request in the next cycle; it is accepted at that cycle's closing edge.
    task automatic issue(input md_opt_e op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        md_if.md_valid_i     = 1'b1;
        md_if.md_operate_i   = op;
        md_if.md_operand_a_i = a;
        md_if.md_operand_b_i = b;
        #1;
    endtask

    // From the request cycle, count cycles to the result pulse and stalled cycles.
    task automatic wait_result(input string tag, input logic [31:0] exp_res, input int exp_lat);
        int lat    = 0;
        int stalls = 0;
        bit got    = 1'b0;
        while (!got && lat < 60) begin
            if (md_if.md_stall_o) stalls++;
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (md_if.md_result_valid_o) got = 1'b1;
        end
        chk({tag, "_pulse"},  {31'd0, got}, 32'd1);
        chk({tag, "_lat"},    lat, exp_lat);
        chk({tag, "_stall"},  stalls, exp_lat);
        chk({tag, "_res"},    md_if.md_result_o, exp_res);
        chk({tag, "_rdy_done"}, {31'd0, md_if.md_ready_o}, 32'd0);
    endtask

    task automatic drop();
        md_if.md_valid_i   = 1'b0;
        md_if.md_operate_i = MD_NONE;
    endtask

    task automatic run(input string tag, input md_opt_e op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        issue(op, a, b);
        wait_result(tag, exp_res, exp_lat);
        drop();
    endtask

    initial begin
        int pulses;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        md_if.md_valid_i     = 1'b0;
        md_if.md_operate_i   = MD_NONE;
        md_if.md_operand_a_i = 32'd0;
        md_if.md_operand_b_i = 32'd0;
        md_if.md_kill_i      = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_res",   md_if.md_result_o, 32'd0);
        chk("rst_rv",    {31'd0, md_if.md_result_valid_o}, 32'd0);
        chk("rst_stall", {31'd0, md_if.md_stall_o}, 32'd0);
        chk("rst_ready", {31'd0, md_if.md_ready_o}, 32'd1);
        rst_n = 1'b1;

        // MD_NONE with valid is never accepted
        issue(MD_NONE, 32'd1, 32'd1);
        chk("none_stall", {31'd0, md_if.md_stall_o}, 32'd0);
        @(negedge clk);
        chk("none_ready", {31'd0, md_if.md_ready_o}, 32'd1);
        drop();

        run("mul",    MD_OP_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
        run("mulhu",  MD_OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
        run("mulh",   MD_OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
        run("mulhsu", MD_OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
        run("div",    MD_OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34);
        run("rem",    MD_OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34);
        run("divu",   MD_OP_DIVU,   32'd100,       32'd7,         32'd14,        34);
        run("remu",   MD_OP_REMU,   32'd100,       32'd7,         32'd2,         34);
        run("divu0",  MD_OP_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 1);
        run("rem0",   MD_OP_REM,    32'd5,         32'd0,         32'd5,         1);
        run("divovf", MD_OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run("removf", MD_OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

        // Kill in the request cycle blocks acceptance
        issue(MD_OP_DIVU, 32'd9, 32'd3);
        md_if.md_kill_i = 1'b1;
        #1;
        chk("kacc_stall", {31'd0, md_if.md_stall_o}, 32'd0);
        @(negedge clk);
        md_if.md_kill_i = 1'b0;
        drop();
        #1;
        chk("kacc_ready", {31'd0, md_if.md_ready_o}, 32'd1);

        // Kill at iteration 10 of a divide; last result was 0 (REM overflow)
        issue(MD_OP_DIVU, 32'h1234_5678, 32'd7);
        repeat (10) @(negedge clk);
        md_if.md_kill_i = 1'b1;
        #1;
        chk("kill_rv", {31'd0, md_if.md_result_valid_o}, 32'd0);
        @(negedge clk);
        md_if.md_kill_i = 1'b0;
        drop();
        #1;
        chk("kill_ready", {31'd0, md_if.md_ready_o}, 32'd1);
        chk("kill_res",   md_if.md_result_o, 32'd0);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (md_if.md_result_valid_o) pulses++;
        end
        chk("kill_nopulse", pulses, 0);
        run("kill_next", MD_OP_DIVU, 32'd9, 32'd3, 32'd3, 34);

        // Same sequence with reset instead of kill; reset clears the result
        issue(MD_OP_DIVU, 32'h1234_5678, 32'd7);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drop();
        #1;
        chk("rstk_ready", {31'd0, md_if.md_ready_o}, 32'd1);
        chk("rstk_stall", {31'd0, md_if.md_stall_o}, 32'd0);
        chk("rstk_res",   md_if.md_result_o, 32'd0);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (md_if.md_result_valid_o) pulses++;
        end
        chk("rstk_nopulse", pulses, 0);
        run("rstk_next", MD_OP_DIVU, 32'd9, 32'd3, 32'd3, 34);

        // Back-to-back: next request appears during DONE, must wait for IDLE
        issue(MD_OP_MUL, 32'd3, 32'd4);
        wait_result("b2b_mul", 32'd12, 34);
        md_if.md_operate_i   = MD_OP_REMU;
        md_if.md_operand_a_i = 32'd10;
        md_if.md_operand_b_i = 32'd4;
        #1;
        chk("b2b_done_stall", {31'd0, md_if.md_stall_o}, 32'd0);
        @(negedge clk);
        #1;
        chk("b2b_idle_ready", {31'd0, md_if.md_ready_o}, 32'd1);
        chk("b2b_idle_stall", {31'd0, md_if.md_stall_o}, 32'd1);
        wait_result("b2b_remu", 32'd2, 34);
        drop();
        @(negedge clk);
        chk("b2b_hold_res", md_if.md_result_o, 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/md_sequencer.md
# md_sequencer

Multi-cycle sequencer for the M-extension multiply/divide operations issued by the decoder (MD_OP_MUL … MD_OP_REMU). It sits in the EX stage beside the ALU and accepts one request at a time from the ID-EX register. It runs a 32-iteration shift-add multiply or restoring divide on operand magnitudes, then applies sign correction. While busy it stalls the front of the pipeline, and it delivers a registered 32-bit result with a one-cycle valid pulse.

## Interface
- No parameters; datapath width fixed at 32.
- Reset: one clock; reset is synchronous and active-low.
- clk_i  input  1  clock, all state updates on rising edge
- rst_ni  input  1  synchronous active-low reset
- md_valid_i  input  1  request present (md_sel from ID-EX); held stable while md_stall_o=1
- md_operate_i  input  milano_pkg::md_opt_e  operation; MD_NONE is never accepted
- md_operand_a_i  input  32  rs1 value (multiplicand / dividend)
- md_operand_b_i  input  32  rs2 value (multiplier / divisor)
- md_kill_i  input  1  flush from taken jump/branch; aborts any operation
- md_ready_o  output  1  state==IDLE
- md_stall_o  output  1  hold PC, IF-ID and ID-EX
- md_result_o  output  32  registered result
- md_result_valid_o  output  1  one-cycle result pulse

## Operation
- States: IDLE, MUL, DIV, FIXUP, DONE.
- Accept condition: IDLE, md_valid_i=1, md_operate_i≠MD_NONE, md_kill_i=0. On accept, latch op, |a|, |b|, sign flags, and clear the 6-bit counter.
- Signedness:
  - MULH, DIV, REM: both operands signed.
  - MULHSU: a signed, b unsigned.
  - MUL, MULU, DIVU, REMU: unsigned.
  - MUL low word is sign-agnostic.
- IDLE transitions:
  - Mul ops → MUL.
  - Div/rem ops with b=0 → DONE. Result: DIV/DIVU 0xFFFFFFFF; REM/REMU a.
  - DIV/REM with a=0x80000000 and b=0xFFFFFFFF → DONE. Result: DIV 0x80000000; REM 0.
  - Other div ops → DIV.
- MUL: each cycle, if multiplier bit 0 is set, add the multiplicand into the upper half of the 64-bit accumulator; then shift right. After 32 iterations → FIXUP.
- DIV: restoring division, one quotient bit per cycle, 33-bit partial remainder. After 32 iterations → FIXUP.
- FIXUP:
  - Mul: negate the 64-bit product if signs differ.
  - Div: negate the quotient if signs differ (DIV only); the remainder takes the dividend's sign (REM only).
  - Select the word: MUL→[31:0]; MULH/MULHSU/MULU→[63:32]; DIV/DIVU→quotient; REM/REMU→remainder.
  - Register md_result_o, then → DONE.
- DONE: md_result_valid_o=1 unless md_kill_i; → IDLE.
- md_kill_i=1 in any state: next state IDLE, counter cleared, no result pulse, md_result_o keeps its old value. A kill in the accept cycle prevents acceptance.
- md_stall_o=1 when:
  - (IDLE and accept condition), or
  - state ∈ {MUL, DIV, FIXUP}.
- md_stall_o=0 in DONE, so the pipeline advances while the result is valid. md_ready_o=0 in DONE, so the held request is not re-accepted.

## Timing
- Reset (rst_ni=0 at an edge): state IDLE, counter 0, md_result_o=0, md_result_valid_o=0, md_stall_o=0, md_ready_o=1. Reset mid-operation discards all state.
- Accept at edge k (request visible in cycle k):
  - Normal path: MUL/DIV cycles k+1…k+32, FIXUP k+33, DONE k+34. md_stall_o high cycles k…k+33 (34 cycles).
  - Fast path (div-by-zero, overflow): DONE at cycle k+1; md_stall_o high only in cycle k.
- md_result_o is stable from DONE until the next FIXUP or fast-path DONE.
- Back-to-back: after DONE, the next request can be accepted in the following IDLE cycle. There is one idle cycle between results.
- Combinational outputs: md_stall_o and md_ready_o depend on state plus md_valid_i/md_operate_i/md_kill_i. md_result_valid_o depends on state and md_kill_i.

## Test plan
- MUL a=7, b=0xFFFFFFFD → md_result_o=0xFFFFFFEB, pulse at accept+34, md_stall_o high exactly 34 cycles.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULH 0x80000000×0x80000000 → 0x40000000; MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 → 0xFFFFFFFD; REM → 0xFFFFFFFF; DIVU 100/7 → 14; REMU → 2.
- DIVU 5/0 → 0xFFFFFFFF and REM 5/0 → 5, each pulse at accept+1. DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM → 0, same timing.
- Kill mid-operation:
  - DIVU with md_kill_i pulsed at iteration 10 → no pulse, md_ready_o=1 next cycle, md_result_o unchanged.
  - Next DIVU 9/3 → 3.
  - Same sequence with rst_ni low instead of kill gives the same recovery.
- Back-to-back MUL 3×4 then REMU 10/4 → results 12 then 2. Second accept occurs exactly one cycle after the first DONE, with no duplicate acceptance during DONE.
